// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freeze / redirect / load-use resolution plus a
// small interrupt-entry FSM that drains the front end before vectoring.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        branch_taken,
    input  logic        reti,
    input  logic        mem_busy,
    input  logic        interrupt_req,
    input  logic        interrupt_mask,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_mem_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        pc_sel_vector,
    output logic        int_ack,
    output logic        int_active,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        VECTOR = 2'd2,
        ISR    = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        drain_cnt_q, drain_cnt_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;

    logic redirect;
    logic load_use;
    logic irq_take;
    logic stall_inc;

    always_comb begin
        redirect  = branch_taken | reti;
        load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));
        irq_take  = interrupt_req && !interrupt_mask && !mem_busy && !redirect;
        stall_inc = mem_busy || (load_use && !redirect);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            drain_cnt_q    <= 1'b0;
            stall_cycles_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            drain_cnt_q    <= drain_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // The drain counter advances even while frozen, so busy cycles overlap the
    // two-cycle minimum rather than adding to it.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            RUN: begin
                if (irq_take) begin
                    state_d     = DRAIN;
                    drain_cnt_d = 1'b0;
                end
            end
            DRAIN: begin
                drain_cnt_d = 1'b1;
                if (drain_cnt_q && !mem_busy) begin
                    state_d = VECTOR;
                end
            end
            VECTOR: begin
                state_d     = ISR;
                drain_cnt_d = 1'b0;
            end
            ISR: begin
                if (reti && !mem_busy) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d     = RUN;
                drain_cnt_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_inc && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        ex_mem_stall  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        pc_sel_vector = 1'b0;
        int_ack       = 1'b0;
        int_active    = 1'b0;

        if (mem_busy) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
        end else if (redirect) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_flush  = 1'b1;
        end

        // State overlays; IF/ID stall is dropped wherever IF/ID is flushed.
        case (state_q)
            DRAIN: begin
                if (!mem_busy) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b0;
                    if_id_flush = 1'b1;
                end
            end
            VECTOR: begin
                pc_stall      = 1'b0;
                if_id_stall   = 1'b0;
                if_id_flush   = 1'b1;
                pc_sel_vector = 1'b1;
                int_ack       = 1'b1;
            end
            ISR: begin
                int_active = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk (posedge), rst_n (active-low, asynchronous assert).
REQ-002 clk  input  1  pipeline clock.
REQ-003 rst_n  input  1  async active-low reset.
REQ-004 id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-005 ex_rd  input  5  destination register of the instruction in EX.
REQ-006 ex_mem_read  input  1  EX instruction is a load.
REQ-007 branch_taken  input  1  EX resolved a taken branch/jump this cycle.
REQ-008 reti  input  1  EX holds a return-from-interrupt (acts as taken branch).
REQ-009 mem_busy  input  1  data memory not ready; whole pipe must freeze.
REQ-010 interrupt_req  input  1  level interrupt request.
REQ-011 interrupt_mask  input  1  1 = interrupts blocked.
REQ-012 pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  output  1 each  hold the PC / pipeline register.
REQ-013 if_id_flush, id_ex_flush  output  1 each  clear the pipeline register to a bubble.
REQ-014 pc_sel_vector  output  1  PC loads the interrupt vector this cycle.
REQ-015 int_ack  output  1  one-cycle acknowledge to the interrupt source.
REQ-016 int_active  output  1  ISR in progress (FSM in ISR).
REQ-017 stall_cycles  output  16  saturating count of freeze and load-use cycles.

Function
REQ-018 Hazard outputs SHALL be combinational from the inputs and the FSM state; the FSM and counter SHALL be registered.
REQ-019 Priority SHALL be: mem_busy > (branch_taken | reti) > load-use.
REQ-020 mem_busy=1: pc_stall = if_id_stall = id_ex_stall = ex_mem_stall = 1; all flushes 0 regardless of other inputs.
REQ-021 Redirect ((branch_taken | reti) and !mem_busy): if_id_flush = id_ex_flush = 1; all stalls 0.
REQ-022 Load-use = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
REQ-023 Load-use with no higher-priority event: pc_stall = if_id_stall = id_ex_flush = 1, which gives exactly one bubble.
REQ-024 The FSM SHALL have the states RUN, DRAIN, VECTOR and ISR.
REQ-025 RUN->DRAIN SHALL occur on interrupt_req & !interrupt_mask & !mem_busy & !branch_taken & !reti; otherwise the request is deferred and re-evaluated next cycle.
REQ-026 DRAIN SHALL last a minimum of 2 cycles, tracked by a 1-bit drain counter, and extend while mem_busy=1.
REQ-027 In DRAIN, pc_stall = if_id_flush = 1; id_ex_flush follows REQ-021/023.
REQ-028 DRAIN->VECTOR SHALL occur when the drain counter is done and mem_busy=0.
REQ-029 VECTOR SHALL be exactly 1 cycle with pc_sel_vector = int_ack = if_id_flush = 1 and pc_stall = 0, followed by the transition to ISR.
REQ-030 In ISR, int_active=1, interrupt_req is ignored (no nesting), and hazard rules apply as in RUN.
REQ-031 ISR->RUN SHALL occur on reti & !mem_busy.
REQ-032 reti seen in RUN SHALL be treated as a plain redirect with no state change.
REQ-033 stall_cycles SHALL increment by 1 on every cycle with mem_busy=1 or with load-use active per REQ-023, and SHALL saturate at 16'hFFFF without wrapping.
REQ-034 A stall and a flush of the same pipeline register SHALL never be asserted together.

Reset
REQ-035 On rst_n=0, the FSM SHALL enter RUN immediately, even mid-DRAIN/VECTOR/ISR.
REQ-036 On rst_n=0, the drain counter and stall_cycles SHALL clear to 0.
REQ-037 On rst_n=0, pc_sel_vector, int_ack and int_active SHALL be 0, and the hazard outputs SHALL reflect the inputs in RUN.
REQ-038 No pending interrupt SHALL be remembered across reset.

Verification
REQ-039 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 -> pc_stall=if_id_stall=id_ex_flush=1 for 1 cycle, stall_cycles 0->1; ex_rd=0 -> no stall.
REQ-040 Priority: mem_busy=1 with branch_taken=1 and a load-use match -> all four stalls 1 and both flushes 0; mem_busy drops -> redirect flush next cycle.
REQ-041 Interrupt: interrupt_req=1, mask=0 in RUN -> DRAIN 2 cycles, VECTOR 1 cycle (pc_sel_vector=int_ack=1), then int_active=1; reti -> RUN with both flushes 1.
REQ-042 Deferral: interrupt_req with interrupt_mask=1, or coincident with branch_taken -> no DRAIN that cycle; the request is taken the first cycle both are clear. A second interrupt_req during ISR -> ignored.
REQ-043 mem_busy=1 for 3 cycles during DRAIN -> DRAIN lasts 4 cycles total and VECTOR follows; stall_cycles +3.
REQ-044 Saturation/reset: preload stall_cycles=16'hFFFE and hold mem_busy 3 cycles -> 16'hFFFF held; assert rst_n=0 in VECTOR -> RUN, outputs 0, counter 0.
